// File: rtl/enemy_tick_random_gen_if.sv
// Frame-tick / random-direction bundle between the tick generator and its host.
interface enemy_tick_random_gen_if;
    logic        startOfFrame;
    logic        enable;
    logic [1:0]  speed_sel;
    logic        seed_load;
    logic [15:0] seed_value;
    logic        timer_done;
    logic [3:0]  random;
    logic [7:0]  tick_count;

    modport master (
        output startOfFrame, enable, speed_sel, seed_load, seed_value,
        input  timer_done, random, tick_count
    );

    modport slave (
        input  startOfFrame, enable, speed_sel, seed_load, seed_value,
        output timer_done, random, tick_count
    );
endinterface

// File: rtl/enemy_tick_random_gen.sv
// Frame-divided move strobe with a registered 4-bit direction drawn from a
// free-running 16-bit Galois LFSR.
module enemy_tick_random_gen #(
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int unsigned FRAMES_PER_TICK = 4
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    enemy_tick_random_gen_if.slave bus
);
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [7:0]  FPT       = FRAMES_PER_TICK[7:0];

    logic [15:0] lfsr_q, lfsr_d, lfsr_step;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  tick_count_q, tick_count_d;
    logic [7:0]  shifted, period;
    logic [3:0]  random_q, random_d;
    logic        timer_done_q, timer_done_d;

    always_comb begin
        shifted   = FPT >> bus.speed_sel;
        period    = (shifted == '0) ? 8'd1 : shifted;
        lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    end

    always_comb begin
        lfsr_d       = lfsr_q;
        frame_cnt_d  = frame_cnt_q;
        tick_count_d = tick_count_q;
        random_d     = random_q;
        timer_done_d = 1'b0;
        if (bus.seed_load) begin
            lfsr_d      = (bus.seed_value == '0) ? LFSR_SEED : bus.seed_value;
            frame_cnt_d = '0;
        end else if (bus.enable) begin
            lfsr_d = lfsr_step;
            if (bus.startOfFrame) begin
                // >= so that a lowered period fires on the next frame
                if (frame_cnt_q >= period - 8'd1) begin
                    frame_cnt_d  = '0;
                    timer_done_d = 1'b1;
                    random_d     = lfsr_q[3:0];
                    tick_count_d = tick_count_q + 8'd1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            lfsr_q       <= LFSR_SEED;
            frame_cnt_q  <= '0;
            tick_count_q <= '0;
            random_q     <= '0;
            timer_done_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            frame_cnt_q  <= frame_cnt_d;
            tick_count_q <= tick_count_d;
            random_q     <= random_d;
            timer_done_q <= timer_done_d;
        end
    end

    assign bus.timer_done = timer_done_q;
    assign bus.random     = random_q;
    assign bus.tick_count = tick_count_q;
endmodule

// File: tb/tb_enemy_tick_random_gen.sv
// Bench for enemy_tick_random_gen: behavioural model feeds a tick scoreboard;
// each scenario task adds its own directed checks.
module tb_enemy_tick_random_gen;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          FPT  = 4;

    logic CLK    = 1'b0;
    logic RESETn = 1'b1;

    enemy_tick_random_gen_if bus();

    enemy_tick_random_gen #(.LFSR_SEED(SEED), .FRAMES_PER_TICK(FPT)) dut (
        .CLK   (CLK),
        .RESETn(RESETn),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_lfsr;
    int          m_cnt;
    logic        m_td;
    logic [3:0]  m_rand;
    logic [7:0]  m_ticks;
    logic [11:0] exp_q[$];
    logic [11:0] e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int period_of(input logic [1:0] s);
        int p;
        p = (FPT >> s) & 255;
        return (p == 0) ? 1 : p;
    endfunction

    // reference model; each tick pushes {random, tick_count} to the scoreboard
    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            m_lfsr  <= SEED;
            m_cnt   <= 0;
            m_td    <= 1'b0;
            m_rand  <= 4'd0;
            m_ticks <= 8'd0;
            exp_q.delete();
        end else begin
            m_td <= 1'b0;
            if (bus.seed_load) begin
                m_lfsr <= (bus.seed_value == 16'd0) ? SEED : bus.seed_value;
                m_cnt  <= 0;
            end else if (bus.enable) begin
                m_lfsr <= lfsr_next(m_lfsr);
                if (bus.startOfFrame) begin
                    if (m_cnt + 1 >= period_of(bus.speed_sel)) begin
                        m_cnt   <= 0;
                        m_td    <= 1'b1;
                        m_rand  <= m_lfsr[3:0];
                        m_ticks <= m_ticks + 8'd1;
                        exp_q.push_back({m_lfsr[3:0], m_ticks + 8'd1});
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (RESETn) begin
            checks++;
            if ({bus.timer_done, bus.random, bus.tick_count} !== {m_td, m_rand, m_ticks}) begin
                failures++;
                $display("FAIL model_state td/rand/cnt got=%0b/%h/%0d exp=%0b/%h/%0d",
                         bus.timer_done, bus.random, bus.tick_count, m_td, m_rand, m_ticks);
            end
            if (bus.timer_done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_tick got=1 exp=no tick pending");
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.random, bus.tick_count} !== e) begin
                        failures++;
                        $display("FAIL sb_tick rand/cnt got=%h/%0d exp=%h/%0d",
                                 bus.random, bus.tick_count, e[11:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        bus.startOfFrame = 1'b0;
        bus.enable       = 1'b0;
        bus.speed_sel    = 2'd0;
        bus.seed_load    = 1'b0;
        bus.seed_value   = 16'd0;
        RESETn = 1'b0;
        repeat (2) @(negedge CLK);
        #1 RESETn = 1'b1;
    endtask

    task automatic set_enable(input logic en);
        @(negedge CLK);
        #1 bus.enable = en;
    endtask

    task automatic pulse(output logic td, output logic [7:0] tc, output logic td_after);
        @(negedge CLK);
        #1 bus.startOfFrame = 1'b1;
        @(negedge CLK);
        td = bus.timer_done;
        tc = bus.tick_count;
        #1 bus.startOfFrame = 1'b0;
        @(negedge CLK);
        td_after = bus.timer_done;
    endtask

    task automatic test_reset();
        bus.startOfFrame = 1'b0;
        bus.enable       = 1'b0;
        bus.speed_sel    = 2'd0;
        bus.seed_load    = 1'b0;
        bus.seed_value   = 16'd0;
        RESETn = 1'b0;
        #3;
        checks++;
        if ({bus.timer_done, bus.random, bus.tick_count} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0b/%h/%0d exp=0/0/0",
                     bus.timer_done, bus.random, bus.tick_count);
        end
        checks++;
        if (dut.lfsr_q !== SEED || dut.frame_cnt_q !== 8'd0) begin
            failures++;
            $display("FAIL reset_state lfsr/cnt got=%h/%0d exp=%h/0", dut.lfsr_q, dut.frame_cnt_q, SEED);
        end
        @(negedge CLK);
        #1 RESETn = 1'b1;
    endtask

    task automatic test_lfsr_trace();
        int steps;
        int zero_seen;
        logic [15:0] trace [3];
        trace[0] = 16'hACE1; trace[1] = 16'hE270; trace[2] = 16'h7138;
        do_reset();
        set_enable(1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut.lfsr_q !== trace[i]) begin
                failures++;
                $display("FAIL lfsr_trace step=%0d got=%h exp=%h", i, dut.lfsr_q, trace[i]);
            end
            @(negedge CLK);
        end
        steps = 3;
        zero_seen = 0;
        while (steps < 70000 && dut.lfsr_q !== SEED) begin
            if (dut.lfsr_q === 16'd0) zero_seen = 1;
            @(negedge CLK);
            steps++;
        end
        checks++;
        if (steps != 65535) begin
            failures++;
            $display("FAIL lfsr_period got=%0d exp=65535", steps);
        end
        checks++;
        if (zero_seen != 0) begin
            failures++;
            $display("FAIL lfsr_zero got=seen exp=never");
        end
    endtask

    task automatic test_basic_ticks();
        logic td, ta;
        logic [7:0] tc;
        do_reset();
        set_enable(1'b1);
        for (int k = 1; k <= 12; k++) begin
            pulse(td, tc, ta);
            checks++;
            if (td !== ((k % 4) == 0)) begin
                failures++;
                $display("FAIL basic_td pulse=%0d got=%0b exp=%0b", k, td, (k % 4) == 0);
            end
            if ((k % 4) == 0) begin
                checks++;
                if (tc !== 8'(k / 4)) begin
                    failures++;
                    $display("FAIL basic_count pulse=%0d got=%0d exp=%0d", k, tc, k / 4);
                end
            end
            checks++;
            if (ta !== 1'b0) begin
                failures++;
                $display("FAIL basic_one_cycle pulse=%0d got=%0b exp=0", k, ta);
            end
            repeat (17) @(negedge CLK);
        end
    endtask

    task automatic test_speed_change();
        logic td, ta;
        logic [7:0] tc;
        logic [1:0] sp [3];
        sp[0] = 2'd2; sp[1] = 2'd2; sp[2] = 2'd3;
        do_reset();
        set_enable(1'b1);
        repeat (2) pulse(td, tc, ta);
        checks++;
        if (dut.frame_cnt_q !== 8'd2 || td !== 1'b0) begin
            failures++;
            $display("FAIL speed_precount cnt/td got=%0d/%0b exp=2/0", dut.frame_cnt_q, td);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1 bus.speed_sel = sp[i];
            pulse(td, tc, ta);
            checks++;
            if ({td, tc, ta} !== {1'b1, 8'(i + 1), 1'b0}) begin
                failures++;
                $display("FAIL speed_fire sel=%0d td/cnt/after got=%0b/%0d/%0b exp=1/%0d/0",
                         sp[i], td, tc, ta, i + 1);
            end
        end
    endtask

    task automatic test_freeze();
        logic td, ta;
        logic [7:0] tc;
        logic [15:0] s_lfsr;
        logic [3:0] s_rand;
        do_reset();
        set_enable(1'b1);
        repeat (6) pulse(td, tc, ta);
        set_enable(1'b0);
        @(negedge CLK);
        s_lfsr = m_lfsr;
        s_rand = m_rand;
        for (int i = 0; i < 5; i++) begin
            pulse(td, tc, ta);
            checks++;
            if (td !== 1'b0) begin
                failures++;
                $display("FAIL freeze_td pulse=%0d got=%0b exp=0", i, td);
            end
            repeat (3) @(negedge CLK);
        end
        checks++;
        if ({dut.lfsr_q, dut.frame_cnt_q, bus.random, bus.tick_count} !== {s_lfsr, 8'd2, s_rand, 8'd1}) begin
            failures++;
            $display("FAIL freeze_hold lfsr/cnt/rand/ticks got=%h/%0d/%h/%0d exp=%h/2/%h/1",
                     dut.lfsr_q, dut.frame_cnt_q, bus.random, bus.tick_count, s_lfsr, s_rand);
        end
        set_enable(1'b1);
        pulse(td, tc, ta);
        checks++;
        if (td !== 1'b0) begin
            failures++;
            $display("FAIL resume_early got=%0b exp=0", td);
        end
        pulse(td, tc, ta);
        checks++;
        if ({td, tc} !== {1'b1, 8'd2}) begin
            failures++;
            $display("FAIL resume_tick td/cnt got=%0b/%0d exp=1/2", td, tc);
        end
    endtask

    task automatic test_seed_load();
        logic td, ta;
        logic [7:0] tc;
        do_reset();
        set_enable(1'b1);
        repeat (2) pulse(td, tc, ta);
        @(negedge CLK);
        #1;
        bus.startOfFrame = 1'b1;
        bus.seed_load    = 1'b1;
        bus.seed_value   = 16'h0000;
        @(negedge CLK);
        checks++;
        if ({dut.lfsr_q, dut.frame_cnt_q, bus.timer_done, bus.tick_count} !== {SEED, 8'd0, 1'b0, 8'd0}) begin
            failures++;
            $display("FAIL seed_zero lfsr/cnt/td/ticks got=%h/%0d/%0b/%0d exp=%h/0/0/0",
                     dut.lfsr_q, dut.frame_cnt_q, bus.timer_done, bus.tick_count, SEED);
        end
        #1;
        bus.startOfFrame = 1'b0;
        bus.seed_load    = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        bus.seed_load  = 1'b1;
        bus.seed_value = 16'h0001;
        @(negedge CLK);
        checks++;
        if (dut.lfsr_q !== 16'h0001) begin
            failures++;
            $display("FAIL seed_one got=%h exp=0001", dut.lfsr_q);
        end
        #1 bus.seed_load = 1'b0;
        @(negedge CLK);
        checks++;
        if (dut.lfsr_q !== 16'hB400) begin
            failures++;
            $display("FAIL seed_step got=%h exp=b400", dut.lfsr_q);
        end
        for (int k = 1; k <= 4; k++) begin
            pulse(td, tc, ta);
            checks++;
            if (td !== (k == 4)) begin
                failures++;
                $display("FAIL seed_tick pulse=%0d got=%0b exp=%0b", k, td, k == 4);
            end
        end
        set_enable(1'b0);
        #1;
        bus.seed_load  = 1'b1;
        bus.seed_value = 16'h1234;
        @(negedge CLK);
        checks++;
        if (dut.lfsr_q !== 16'h1234) begin
            failures++;
            $display("FAIL seed_disabled got=%h exp=1234", dut.lfsr_q);
        end
        #1 bus.seed_load = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_enable(1'b1);
        #1;
        bus.speed_sel    = 2'd2;
        bus.startOfFrame = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({bus.timer_done, bus.tick_count} !== {1'b1, 8'(i)}) begin
                failures++;
                $display("FAIL b2b cycle=%0d td/cnt got=%0b/%0d exp=1/%0d", i, bus.timer_done, bus.tick_count, i);
            end
        end
        #1 bus.startOfFrame = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.timer_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release got=%0b exp=0", bus.timer_done);
        end
    endtask

    task automatic test_async_reset();
        logic td, ta;
        logic [7:0] tc;
        do_reset();
        set_enable(1'b1);
        repeat (3) pulse(td, tc, ta);
        @(negedge CLK);
        #1 bus.startOfFrame = 1'b1;
        @(posedge CLK);
        #2;
        checks++;
        if ({bus.timer_done, bus.tick_count} !== {1'b1, 8'd1}) begin
            failures++;
            $display("FAIL areset_pre td/cnt got=%0b/%0d exp=1/1", bus.timer_done, bus.tick_count);
        end
        RESETn = 1'b0;
        #1;
        checks++;
        if ({bus.timer_done, bus.random, bus.tick_count} !== 13'd0) begin
            failures++;
            $display("FAIL areset_clear td/rand/cnt got=%0b/%h/%0d exp=0/0/0",
                     bus.timer_done, bus.random, bus.tick_count);
        end
        bus.startOfFrame = 1'b0;
        @(negedge CLK);
        #1 RESETn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            pulse(td, tc, ta);
            checks++;
            if (td !== (k == 4)) begin
                failures++;
                $display("FAIL areset_period pulse=%0d got=%0b exp=%0b", k, td, k == 4);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_ticks();
        test_lfsr_trace();
        test_speed_change();
        test_freeze();
        test_seed_load();
        test_back_to_back();
        test_async_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
